vrf_port_sequencer: RTL and testbench
=====================================

VRF_PORT_SEQUENCER -- requirements
Module: vrf_port_sequencer

Sits downstream of the port allocator: one instance per write-port group. It consumes one start pulse, sequences VRF read/write addresses for the instruction, and returns port-ready.

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: VRF address width in beats.
REQ-002 SHALL have parameter BEATS_W, default 6: width of the beat count.
REQ-003 SHALL have the port clk, input, 1: clock, all logic on rising edge.
REQ-004 SHALL have the port rstn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have the port start_i, input, 1: allocation pulse for this port group.
REQ-006 SHALL have the ports vs1_base_i, vs2_base_i, vs3_base_i, vd_base_i, input, ADDR_W each: base beat addresses.
REQ-007 SHALL have the port op3_en_i, input, 1: instruction uses the third read operand (e.g. multiply-accumulate).
REQ-008 SHALL have the port beats_i, input, BEATS_W: number of beats to process.
REQ-009 SHALL have the port rd_stall_i, input, 1: read side not accepting this cycle.
REQ-010 SHALL have the ports rd_vld_o, output, 1, and rd_addr_a_o, rd_addr_b_o, rd_addr_c_o, output, ADDR_W each: read request.
REQ-011 SHALL have the port rd_c_en_o, output, 1: third-operand read port is active.
REQ-012 SHALL have the port wr_data_vld_i, input, 1: lane result beat available.
REQ-013 SHALL have the ports wr_en_o, output, 1, and wr_addr_o, output, ADDR_W: VRF write.
REQ-014 SHALL have the port port_rdy_o, output, 1: group idle and allocatable.
REQ-015 SHALL have the port done_o, output, 1: one-cycle completion pulse.
REQ-016 SHALL have the port err_o, output, 1: sticky protocol error.

Function
REQ-017 SHALL implement states IDLE, READ and DRAIN; port_rdy_o SHALL be 1 exactly when in IDLE.
REQ-018 In IDLE, start_i=1 with beats_i!=0 SHALL latch all bases, op3_en_i and beats_i, clear rd_cnt and wr_cnt, and go to READ next cycle.
REQ-019 In IDLE, start_i=1 with beats_i==0 SHALL stay in IDLE, issue no reads or writes, and pulse done_o the next cycle.
REQ-020 start_i outside IDLE SHALL be ignored and SHALL set err_o.
REQ-021 In READ: rd_vld_o=1; rd_addr_a_o=vs1_base+rd_cnt; rd_addr_b_o=vs2_base+rd_cnt; rd_addr_c_o=vs3_base+rd_cnt.
REQ-022 rd_c_en_o SHALL equal rd_vld_o AND latched op3_en.
REQ-023 A read beat SHALL be accepted when rd_vld_o=1 and rd_stall_i=0, and SHALL increment rd_cnt; under stall, addresses SHALL hold stable.
REQ-024 Acceptance of beat rd_cnt==beats-1 SHALL move READ to DRAIN, unless the final write completes in the same cycle (see REQ-028).
REQ-025 Address sums SHALL be computed modulo 2^ADDR_W (wrap-around).
REQ-026 In READ or DRAIN, wr_data_vld_i=1 with wr_cnt<rd_cnt SHALL assert wr_en_o the same cycle (combinational), set wr_addr_o=vd_base+wr_cnt, and increment wr_cnt.
REQ-027 wr_data_vld_i=1 with wr_cnt>=rd_cnt, or in IDLE, SHALL NOT assert wr_en_o and SHALL set err_o.
REQ-028 The write of beat wr_cnt==beats-1 SHALL return to IDLE next cycle with done_o=1 for that one cycle; this holds also when the final read and final write coincide.
REQ-029 Simultaneous read accept and write in one cycle SHALL both take effect.
REQ-030 A start_i in the cycle done_o is high SHALL be accepted (back-to-back).
REQ-031 rd_vld_o, rd_c_en_o and wr_en_o SHALL be 0 in IDLE.
REQ-032 err_o SHALL be cleared only by reset.

Reset
REQ-033 rstn=0 at a clock edge SHALL force IDLE, zero the counters and latched fields, and set port_rdy_o=1, rd_vld_o=0, wr_en_o=0, done_o=0, err_o=0 and all address outputs=0.
REQ-034 Reset mid-operation SHALL abandon the instruction without emitting done_o.

Verification
REQ-035 Basic: start, beats=3, vs1=10, vs2=20, vd=30, no stall, wr_data_vld_i one cycle after each read -> reads at 10/20, 11/21, 12/22; writes at 30, 31, 32; done_o one cycle after write 32; port_rdy_o high next.
REQ-036 Stall: rd_stall_i=1 for 2 cycles on beat 1 -> rd_addr_a_o holds 11 for 3 cycles; no beat skipped or duplicated.
REQ-037 Wrap: ADDR_W=9, vs1_base=510, beats=4 -> rd_addr_a_o sequence 510, 511, 0, 1.
REQ-038 Zero/op3: beats=0 -> no rd_vld_o, done_o 1 cycle later; op3_en=1, vs3=40 -> rd_c_en_o=1 with rd_addr_c_o 40, 41, ...
REQ-039 Errors: wr_data_vld_i before any read accepted, or start_i while in READ -> err_o=1 sticky, no wr_en_o, current operation unaffected.
REQ-040 Reset mid-READ after 2 of 5 beats -> IDLE next cycle, port_rdy_o=1, no done_o; a new start then behaves as in REQ-035.

Source files
------------

// File: rtl/vrf_port_sequencer.sv
// vrf_port_sequencer
//   Per write-port-group sequencer. It accepts one start pulse and then
//   walks the VRF read addresses for up to three source operands, one beat
//   at a time. It also walks the write addresses for result beats that come
//   back from the lanes. When the last result beat has been written, it
//   returns to idle and pulses done_o.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   start_i              allocation pulse (accepted only when port_rdy_o=1)
//   vs1/vs2/vs3/vd_base_i base beat addresses, latched on start
//   op3_en_i             instruction reads a third operand
//   beats_i              beat count, latched on start (0 = immediate done)
//   rd_stall_i           read side not accepting this cycle
//   rd_vld_o, rd_addr_a/b/c_o, rd_c_en_o   read request
//   wr_data_vld_i        lane result beat available
//   wr_en_o, wr_addr_o   VRF write (combinational from wr_data_vld_i)
//   port_rdy_o           group idle and allocatable
//   done_o               one-cycle completion pulse
//   err_o                sticky protocol error, cleared only by reset
//
// state | meaning
// IDLE  | waiting for start_i, port_rdy_o=1
// READ  | issuing read beats; result writes may overlap
// DRAIN | all reads accepted, waiting for remaining result writes
module vrf_port_sequencer #(
   parameter int ADDR_W  = 9,
   parameter int BEATS_W = 6
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic [ADDR_W-1:0]  vs1_base_i,
   input  logic [ADDR_W-1:0]  vs2_base_i,
   input  logic [ADDR_W-1:0]  vs3_base_i,
   input  logic [ADDR_W-1:0]  vd_base_i,
   input  logic               op3_en_i,
   input  logic [BEATS_W-1:0] beats_i,
   input  logic               rd_stall_i,
   output logic               rd_vld_o,
   output logic [ADDR_W-1:0]  rd_addr_a_o,
   output logic [ADDR_W-1:0]  rd_addr_b_o,
   output logic [ADDR_W-1:0]  rd_addr_c_o,
   output logic               rd_c_en_o,
   input  logic               wr_data_vld_i,
   output logic               wr_en_o,
   output logic [ADDR_W-1:0]  wr_addr_o,
   output logic               port_rdy_o,
   output logic               done_o,
   output logic               err_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]         state;
   logic [ADDR_W-1:0]  vs1_q, vs2_q, vs3_q, vd_q;
   logic               op3_q;
   logic [BEATS_W-1:0] beats_q;
   logic [BEATS_W-1:0] rd_cnt, wr_cnt;
   logic               done_q, err_q;

   logic rd_acc, wr_ok, rd_last, wr_last;

   assign rd_vld_o   = (state == S_READ);
   assign rd_c_en_o  = rd_vld_o & op3_q;
   assign port_rdy_o = (state == S_IDLE);
   assign done_o     = done_q;
   assign err_o      = err_q;

   // Sums truncate to ADDR_W, so addresses wrap around naturally.
   assign rd_addr_a_o = vs1_q + ADDR_W'(rd_cnt);
   assign rd_addr_b_o = vs2_q + ADDR_W'(rd_cnt);
   assign rd_addr_c_o = vs3_q + ADDR_W'(rd_cnt);
   assign wr_addr_o   = vd_q  + ADDR_W'(wr_cnt);

   assign rd_acc  = rd_vld_o & ~rd_stall_i;
   // A result beat is only legal once its read has been accepted.
   assign wr_ok   = wr_data_vld_i & (state != S_IDLE) & (wr_cnt < rd_cnt);
   assign wr_en_o = wr_ok;
   assign rd_last = (rd_cnt == beats_q - BEATS_W'(1));
   assign wr_last = (wr_cnt == beats_q - BEATS_W'(1));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= S_IDLE;
         vs1_q   <= '0;
         vs2_q   <= '0;
         vs3_q   <= '0;
         vd_q    <= '0;
         op3_q   <= 1'b0;
         beats_q <= '0;
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if ((start_i && state != S_IDLE) || (wr_data_vld_i && !wr_ok))
            err_q <= 1'b1;
         if (rd_acc) rd_cnt <= rd_cnt + BEATS_W'(1);
         if (wr_ok)  wr_cnt <= wr_cnt + BEATS_W'(1);

         case (state)
            S_IDLE: begin
               if (start_i) begin
                  if (beats_i != '0) begin
                     vs1_q   <= vs1_base_i;
                     vs2_q   <= vs2_base_i;
                     vs3_q   <= vs3_base_i;
                     vd_q    <= vd_base_i;
                     op3_q   <= op3_en_i;
                     beats_q <= beats_i;
                     rd_cnt  <= '0;
                     wr_cnt  <= '0;
                     state   <= S_READ;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            S_READ: begin
               // Final write wins over final read so done is never lost.
               if (wr_ok && wr_last) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end else if (rd_acc && rd_last) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (wr_ok && wr_last) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vrf_port_sequencer.sv
// tb_vrf_port_sequencer
//   Directed bench for vrf_port_sequencer. Inputs change on the falling
//   edge and outputs are sampled 1 ns later, before the next rising edge.
module tb_vrf_port_sequencer;

   localparam int ADDR_W  = 9;
   localparam int BEATS_W = 6;

   logic               clk;
   logic               rstn;
   logic               start_i;
   logic [ADDR_W-1:0]  vs1_base_i, vs2_base_i, vs3_base_i, vd_base_i;
   logic               op3_en_i;
   logic [BEATS_W-1:0] beats_i;
   logic               rd_stall_i;
   logic               rd_vld_o;
   logic [ADDR_W-1:0]  rd_addr_a_o, rd_addr_b_o, rd_addr_c_o;
   logic               rd_c_en_o;
   logic               wr_data_vld_i;
   logic               wr_en_o;
   logic [ADDR_W-1:0]  wr_addr_o;
   logic               port_rdy_o;
   logic               done_o;
   logic               err_o;

   int n_cmp = 0;
   int n_bad = 0;

   vrf_port_sequencer #(.ADDR_W(ADDR_W), .BEATS_W(BEATS_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (start_i),
      .vs1_base_i   (vs1_base_i),
      .vs2_base_i   (vs2_base_i),
      .vs3_base_i   (vs3_base_i),
      .vd_base_i    (vd_base_i),
      .op3_en_i     (op3_en_i),
      .beats_i      (beats_i),
      .rd_stall_i   (rd_stall_i),
      .rd_vld_o     (rd_vld_o),
      .rd_addr_a_o  (rd_addr_a_o),
      .rd_addr_b_o  (rd_addr_b_o),
      .rd_addr_c_o  (rd_addr_c_o),
      .rd_c_en_o    (rd_c_en_o),
      .wr_data_vld_i(wr_data_vld_i),
      .wr_en_o      (wr_en_o),
      .wr_addr_o    (wr_addr_o),
      .port_rdy_o   (port_rdy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle and return just after the next falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic quiet();
      start_i = 0; wr_data_vld_i = 0; rd_stall_i = 0;
   endtask

   task automatic launch(input int nb, input int a, input int b, input int c,
                         input int d, input logic op3);
      start_i = 1; beats_i = BEATS_W'(nb);
      vs1_base_i = ADDR_W'(a); vs2_base_i = ADDR_W'(b);
      vs3_base_i = ADDR_W'(c); vd_base_i = ADDR_W'(d); op3_en_i = op3;
   endtask

   // beats=3, vs1=10, vs2=20, vd=30, each write one cycle after its read
   task automatic run_basic(input string pfx);
      quiet(); launch(3, 10, 20, 0, 30, 0); #1;
      chk({pfx, ".rdy_idle"}, port_rdy_o, 1);
      step(); quiet(); #1;
      chk({pfx, ".vld0"}, rd_vld_o, 1);
      chk({pfx, ".a0"}, rd_addr_a_o, 10);
      chk({pfx, ".b0"}, rd_addr_b_o, 20);
      chk({pfx, ".cen0"}, rd_c_en_o, 0);
      chk({pfx, ".rdy_busy"}, port_rdy_o, 0);
      chk({pfx, ".nowr0"}, wr_en_o, 0);
      for (int i = 1; i < 3; i++) begin
         step(); quiet(); wr_data_vld_i = 1; #1;
         chk({pfx, ".a"}, rd_addr_a_o, 10 + i);
         chk({pfx, ".b"}, rd_addr_b_o, 20 + i);
         chk({pfx, ".wen"}, wr_en_o, 1);
         chk({pfx, ".waddr"}, wr_addr_o, 30 + i - 1);
      end
      step(); quiet(); wr_data_vld_i = 1; #1;
      chk({pfx, ".drain_vld"}, rd_vld_o, 0);
      chk({pfx, ".wen_last"}, wr_en_o, 1);
      chk({pfx, ".waddr_last"}, wr_addr_o, 32);
      chk({pfx, ".nodone"}, done_o, 0);
      step(); quiet(); #1;
      chk({pfx, ".done"}, done_o, 1);
      chk({pfx, ".rdy_end"}, port_rdy_o, 1);
      chk({pfx, ".vld_end"}, rd_vld_o, 0);
      step(); #1;
      chk({pfx, ".done_1cyc"}, done_o, 0);
      chk({pfx, ".err"}, err_o, 0);
   endtask

   initial begin
      rstn = 0; quiet(); launch(0, 0, 0, 0, 0, 0); start_i = 0;
      step(); step(); rstn = 1; #1;
      chk("rst.rdy", port_rdy_o, 1);
      chk("rst.vld", rd_vld_o, 0);
      chk("rst.wen", wr_en_o, 0);
      chk("rst.done", done_o, 0);
      chk("rst.err", err_o, 0);
      chk("rst.a", rd_addr_a_o, 0);
      chk("rst.c", rd_addr_c_o, 0);
      chk("rst.wa", wr_addr_o, 0);

      run_basic("basic");

      // Stall on beat 1 for two cycles; writes only happen in DRAIN.
      quiet(); launch(3, 10, 20, 0, 30, 0);
      step(); quiet(); #1;
      chk("stall.a0", rd_addr_a_o, 10);
      for (int i = 0; i < 3; i++) begin
         step(); quiet(); rd_stall_i = (i < 2); #1;
         chk("stall.hold", rd_addr_a_o, 11);
         chk("stall.vld", rd_vld_o, 1);
      end
      step(); quiet(); #1;
      chk("stall.a2", rd_addr_a_o, 12);
      for (int i = 0; i < 3; i++) begin
         step(); quiet(); wr_data_vld_i = 1; #1;
         chk("stall.drain", rd_vld_o, 0);
         chk("stall.wen", wr_en_o, 1);
         chk("stall.waddr", wr_addr_o, 30 + i);
      end
      step(); quiet(); #1;
      chk("stall.done", done_o, 1);

      // Wrap-around with third operand, writes overlapping reads.
      step(); quiet(); launch(4, 510, 0, 40, 100, 1);
      step(); quiet(); #1;
      chk("wrap.a0", rd_addr_a_o, 510);
      chk("wrap.c0", rd_addr_c_o, 40);
      chk("wrap.cen", rd_c_en_o, 1);
      for (int i = 1; i < 4; i++) begin
         step(); quiet(); wr_data_vld_i = 1; #1;
         chk("wrap.a", rd_addr_a_o, (510 + i) % 512);
         chk("wrap.c", rd_addr_c_o, 40 + i);
         chk("wrap.waddr", wr_addr_o, 100 + i - 1);
      end
      step(); quiet(); wr_data_vld_i = 1; #1;
      chk("wrap.cen_drain", rd_c_en_o, 0);
      chk("wrap.waddr_last", wr_addr_o, 103);
      // Back-to-back start in the done cycle, one beat.
      step(); quiet(); launch(1, 5, 6, 0, 7, 0); #1;
      chk("wrap.done", done_o, 1);
      step(); quiet(); #1;
      chk("b2b.vld", rd_vld_o, 1);
      chk("b2b.a", rd_addr_a_o, 5);
      chk("b2b.cen", rd_c_en_o, 0);
      step(); quiet(); wr_data_vld_i = 1; #1;
      chk("b2b.wen", wr_en_o, 1);
      chk("b2b.waddr", wr_addr_o, 7);
      step(); quiet(); #1;
      chk("b2b.done", done_o, 1);
      chk("b2b.err", err_o, 0);

      // Zero beats: no reads, done one cycle later.
      step(); quiet(); launch(0, 1, 2, 3, 4, 1);
      step(); quiet(); #1;
      chk("zero.vld", rd_vld_o, 0);
      chk("zero.done", done_o, 1);
      chk("zero.rdy", port_rdy_o, 1);
      step(); #1;
      chk("zero.done_1cyc", done_o, 0);

      // Early write and start during READ: error, operation continues.
      quiet(); launch(2, 10, 20, 0, 30, 0);
      step(); quiet(); wr_data_vld_i = 1; start_i = 1; beats_i = 9; #1;
      chk("err.nowen", wr_en_o, 0);
      chk("err.a0", rd_addr_a_o, 10);
      step(); quiet(); wr_data_vld_i = 1; #1;
      chk("err.sticky", err_o, 1);
      chk("err.a1", rd_addr_a_o, 11);
      chk("err.waddr", wr_addr_o, 30);
      chk("err.wen", wr_en_o, 1);
      step(); quiet(); wr_data_vld_i = 1; #1;
      chk("err.waddr2", wr_addr_o, 31);
      step(); quiet(); #1;
      chk("err.done", done_o, 1);
      chk("err.still", err_o, 1);

      // Reset after 2 of 5 beats.
      step(); quiet(); launch(5, 10, 20, 0, 30, 0);
      step(); quiet(); #1;
      step(); #1;
      chk("mrst.a1", rd_addr_a_o, 11);
      step(); rstn = 0;
      step(); rstn = 1; #1;
      chk("mrst.rdy", port_rdy_o, 1);
      chk("mrst.vld", rd_vld_o, 0);
      chk("mrst.done", done_o, 0);
      chk("mrst.err", err_o, 0);
      chk("mrst.a", rd_addr_a_o, 0);
      step(); #1;
      chk("mrst.done2", done_o, 0);
      run_basic("again");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
